refractory_inhibit_array: RTL and testbench

Parametrised, multi-channel successor to the single-channel spike inhibit stage. It sits between the neuron threshold/fire logic and downstream synapse/accumulator logic. Per channel it:
- converts raw spike levels into one-cycle accepted pulses;
- holds an Enable window open for a programmable number of quiet cycles;
- enforces a programmable refractory period during which spikes are dropped.

An optional winner-take-all (WTA) mode applies lateral inhibition across channels.

---
 rtl/neuron_pkg.sv | 13 +
 rtl/refractory_inhibit_chan.sv | 91 +++++++++
 rtl/refractory_inhibit_array.sv | 76 +++++++
 tb/tb_refractory_inhibit_array.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the spiking-neuron pipeline: channel state encodings
// and default counter width.
package neuron_pkg;

  localparam int DEF_CW = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_REFRACT = 2'd2
  } state_t;

endpackage

// File: rtl/refractory_inhibit_chan.sv
// One spike channel: rising-edge detect, Enable window with quiet-cycle hold,
// and refractory period. Acc/Force_refr come back from the array-level arbiter.
module refractory_inhibit_chan
  import neuron_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          P_s,
  input  logic          Acc,
  input  logic          Force_refr,
  input  logic [CW-1:0] Hold_len,
  input  logic [CW-1:0] Refr_len,
  output logic          Acc_req,
  output logic          Pulse,
  output logic          Enable,
  output logic          Refr
);

  state_t        state;
  state_t        state_nxt;
  state_t        after_window;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          prev;
  logic [CW:0]   cnt_inc;
  logic [CW:0]   hold_eff;
  logic [CW:0]   refr_ext;

  // One extra bit on the compare path so cnt+1 never wraps.
  assign cnt_inc      = {1'b0, cnt} + (CW + 1)'(1);
  assign hold_eff     = (Hold_len == '0) ? (CW + 1)'(1) : {1'b0, Hold_len};
  assign refr_ext     = {1'b0, Refr_len};
  assign after_window = (Refr_len == '0) ? ST_IDLE : ST_REFRACT;

  assign Acc_req = P_s & ~prev & (state != ST_REFRACT);
  assign Enable  = (state == ST_ACTIVE);
  assign Refr    = (state == ST_REFRACT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_REFRACT: begin
        if (cnt_inc >= refr_ext) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc[CW-1:0];
        end
      end
      ST_IDLE, ST_ACTIVE: begin
        if (Acc) begin
          state_nxt = ST_ACTIVE;
          cnt_nxt   = '0;
        end else if (Force_refr) begin
          state_nxt = after_window;
          cnt_nxt   = '0;
        end else if (state == ST_ACTIVE && !P_s) begin
          if (cnt_inc >= hold_eff) begin
            state_nxt = after_window;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc[CW-1:0];
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // prev resets high so a line already asserted through reset never fires.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      prev  <= 1'b1;
      Pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      prev  <= P_s;
      Pulse <= Acc;
    end
  end

endmodule

// File: rtl/refractory_inhibit_array.sv
// Multi-channel refractory/inhibit stage with optional winner-take-all lateral
// inhibition (lowest channel index wins).
module refractory_inhibit_array
  import neuron_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int CW   = DEF_CW,
  localparam int IW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [N_CH-1:0] P_s,
  input  logic [CW-1:0]   Hold_len,
  input  logic [CW-1:0]   Refr_len,
  input  logic            Wta_en,
  output logic [N_CH-1:0] Pulse,
  output logic [N_CH-1:0] Enable,
  output logic [N_CH-1:0] Refr,
  output logic            Win_valid,
  output logic [IW-1:0]   Win_idx
);

  logic [N_CH-1:0] acc_req;
  logic [N_CH-1:0] grant;
  logic [N_CH-1:0] force_refr;
  logic [IW-1:0]   win_sel;
  logic            any_req;

  assign any_req = |acc_req;

  // Descending scan leaves the lowest requesting index in win_sel.
  always_comb begin
    win_sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (acc_req[i]) win_sel = IW'(i);
    end
  end

  always_comb begin
    grant      = acc_req;
    force_refr = '0;
    if (Wta_en && any_req) begin
      for (int i = 0; i < N_CH; i++) begin
        grant[i] = (IW'(i) == win_sel);
      end
      force_refr = ~grant;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Win_valid <= 1'b0;
      Win_idx   <= '0;
    end else begin
      Win_valid <= Wta_en & any_req;
      if (Wta_en && any_req) Win_idx <= win_sel;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    refractory_inhibit_chan #(.CW(CW)) u_chan (
      .Clk        (Clk),
      .Rst        (Rst),
      .P_s        (P_s[g]),
      .Acc        (grant[g]),
      .Force_refr (force_refr[g]),
      .Hold_len   (Hold_len),
      .Refr_len   (Refr_len),
      .Acc_req    (acc_req[g]),
      .Pulse      (Pulse[g]),
      .Enable     (Enable[g]),
      .Refr       (Refr[g])
    );
  end

endmodule

// File: tb/tb_refractory_inhibit_array.sv
// Directed bench for refractory_inhibit_array: window timing, refractory drop,
// retrigger, winner-take-all, mid-run reset and zero-length settings.
module tb_refractory_inhibit_array;

  logic       Clk;
  logic       Rst;
  logic [3:0] P_s;
  logic [7:0] Hold_len;
  logic [7:0] Refr_len;
  logic       Wta_en;
  logic [3:0] Pulse;
  logic [3:0] Enable;
  logic [3:0] Refr;
  logic       Win_valid;
  logic [1:0] Win_idx;

  int tests_run = 0;
  int fails     = 0;

  refractory_inhibit_array #(.N_CH(4), .CW(8)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .P_s       (P_s),
    .Hold_len  (Hold_len),
    .Refr_len  (Refr_len),
    .Wta_en    (Wta_en),
    .Pulse     (Pulse),
    .Enable    (Enable),
    .Refr      (Refr),
    .Win_valid (Win_valid),
    .Win_idx   (Win_idx)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] p, input logic [3:0] e,
                         input logic [3:0] r);
    chk({tag, ".pulse"},  {28'b0, Pulse},  {28'b0, p});
    chk({tag, ".enable"}, {28'b0, Enable}, {28'b0, e});
    chk({tag, ".refr"},   {28'b0, Refr},   {28'b0, r});
  endtask

  initial begin
    Rst      = 1'b1;
    P_s      = 4'b0000;
    Hold_len = 8'd3;
    Refr_len = 8'd2;
    Wta_en   = 1'b0;
    tick(2);
    chk_out("reset", 4'b0000, 4'b0000, 4'b0000);
    chk("reset.win_valid", {31'b0, Win_valid}, 32'd0);
    chk("reset.win_idx", {30'b0, Win_idx}, 32'd0);
    Rst = 1'b0;
    tick(2);

    // 1: single spike on ch0, hold 3, refractory 2
    P_s = 4'b0001;
    tick(); P_s = 4'b0000;
    chk_out("t1.c1", 4'b0001, 4'b0001, 4'b0000);
    chk("t1.win_valid", {31'b0, Win_valid}, 32'd0);
    tick(); chk_out("t1.c2", 4'b0000, 4'b0001, 4'b0000);
    tick(); chk_out("t1.c3", 4'b0000, 4'b0001, 4'b0000);
    tick(); chk_out("t1.c4", 4'b0000, 4'b0000, 4'b0001);
    tick(); chk_out("t1.c5", 4'b0000, 4'b0000, 4'b0001);
    tick(); chk_out("t1.c6", 4'b0000, 4'b0000, 4'b0000);
    tick();

    // 2: rise during refractory is dropped; rise after it is accepted
    P_s = 4'b0001;
    tick(); P_s = 4'b0000;
    chk_out("t2.c1", 4'b0001, 4'b0001, 4'b0000);
    tick(2);
    tick(); P_s = 4'b0001;
    chk_out("t2.c4", 4'b0000, 4'b0000, 4'b0001);
    tick(); P_s = 4'b0000;
    chk_out("t2.c5", 4'b0000, 4'b0000, 4'b0001);
    tick(); P_s = 4'b0001;
    chk_out("t2.c6", 4'b0000, 4'b0000, 4'b0000);
    tick(); P_s = 4'b0000;
    chk_out("t2.c7", 4'b0001, 4'b0001, 4'b0000);
    tick(5);
    chk_out("t2.drain", 4'b0000, 4'b0000, 4'b0000);
    tick();

    // 3: retrigger on ch2 restarts the quiet count
    P_s = 4'b0100;
    tick(); P_s = 4'b0000;
    chk_out("t3.c1", 4'b0100, 4'b0100, 4'b0000);
    tick(); P_s = 4'b0100;
    chk_out("t3.c2", 4'b0000, 4'b0100, 4'b0000);
    tick(); P_s = 4'b0000;
    chk_out("t3.c3", 4'b0100, 4'b0100, 4'b0000);
    tick(); chk_out("t3.c4", 4'b0000, 4'b0100, 4'b0000);
    tick(); chk_out("t3.c5", 4'b0000, 4'b0100, 4'b0000);
    tick(); chk_out("t3.c6", 4'b0000, 4'b0000, 4'b0100);
    tick(); chk_out("t3.c7", 4'b0000, 4'b0000, 4'b0100);
    tick(); chk_out("t3.c8", 4'b0000, 4'b0000, 4'b0000);

    // 4: WTA with ch0 held ACTIVE, ch1 and ch3 rising together
    P_s = 4'b0001;
    tick();
    chk_out("t4.pre", 4'b0001, 4'b0001, 4'b0000);
    Wta_en = 1'b1;
    P_s    = 4'b1011;
    tick(); P_s = 4'b0001;
    chk_out("t4.c1", 4'b0010, 4'b0010, 4'b1101);
    chk("t4.c1.win_valid", {31'b0, Win_valid}, 32'd1);
    chk("t4.c1.win_idx", {30'b0, Win_idx}, 32'd1);
    tick();
    chk_out("t4.c2", 4'b0000, 4'b0010, 4'b1101);
    chk("t4.c2.win_valid", {31'b0, Win_valid}, 32'd0);
    chk("t4.c2.win_idx", {30'b0, Win_idx}, 32'd1);
    tick(); chk_out("t4.c3", 4'b0000, 4'b0010, 4'b0000);
    P_s = 4'b0000;
    tick(); chk_out("t4.c4", 4'b0000, 4'b0000, 4'b0010);
    Wta_en = 1'b0;
    tick(2);
    chk_out("t4.drain", 4'b0000, 4'b0000, 4'b0000);
    chk("t4.win_idx_hold", {30'b0, Win_idx}, 32'd1);

    // 5: reset while ch0 ACTIVE with its input held high
    P_s = 4'b0001;
    tick(2);
    chk_out("t5.pre", 4'b0000, 4'b0001, 4'b0000);
    Rst = 1'b1;
    tick(); Rst = 1'b0;
    chk_out("t5.rst", 4'b0000, 4'b0000, 4'b0000);
    chk("t5.rst.win_idx", {30'b0, Win_idx}, 32'd0);
    tick(2);
    chk_out("t5.held", 4'b0000, 4'b0000, 4'b0000);
    P_s = 4'b0000;
    tick(); P_s = 4'b0001;
    tick(); P_s = 4'b0000;
    chk_out("t5.refire", 4'b0001, 4'b0001, 4'b0000);
    tick(6);
    chk_out("t5.drain", 4'b0000, 4'b0000, 4'b0000);

    // 6: zero lengths -> one-cycle window, no refractory
    Hold_len = 8'd0;
    Refr_len = 8'd0;
    P_s = 4'b0001;
    tick(); P_s = 4'b0000;
    chk_out("t6.c1", 4'b0001, 4'b0001, 4'b0000);
    tick(); P_s = 4'b0001;
    chk_out("t6.c2", 4'b0000, 4'b0000, 4'b0000);
    tick(); P_s = 4'b0000;
    chk_out("t6.c3", 4'b0001, 4'b0001, 4'b0000);
    tick();
    chk_out("t6.c4", 4'b0000, 4'b0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
